pattern_scheduler: RTL and testbench
====================================

Name: pattern_scheduler

Overview:
Frame-synchronous scheduler for the test-pattern datapath driven by the video timing/colour-bar generator. It watches the generator's vertical sync and selects which test pattern is shown. In auto mode it cycles through the patterns after a fixed number of frames. An external requester (key debouncer or UART command decoder) can force a specific pattern through a valid/ready handshake. Every pattern change is applied only at a frame boundary, inside vertical blanking, so no frame is ever torn.

Parameters:
NUM_PATTERNS, 8, number of selectable patterns; legal pattern indices are 0..NUM_PATTERNS-1 (minimum 2).
SEL_W, 3, width of the pattern index; must satisfy 2^SEL_W >= NUM_PATTERNS.
FRAMES_PER_PATTERN, 60, dwell time in auto mode, in frames (minimum 1).
CNT_W, 8, width of the frame counter; must satisfy 2^CNT_W > FRAMES_PER_PATTERN.
VS_POL, 1'b1, active level of vs_in (1 = positive, 0 = negative).

Ports:
clk  in  1  pixel clock; same domain as the timing generator.
rst  in  1  asynchronous, active-high reset.
vs_in  in  1  vertical sync from the timing generator.
mode_auto  in  1  level input; 1 = auto-cycle, 0 = hold the current pattern.
req_valid  in  1  a manual pattern request is present.
req_pattern  in  SEL_W  requested pattern index.
req_ready  out  1  the scheduler can accept a request.
pattern_sel  out  SEL_W  current pattern index, fed to the pattern datapath.
pattern_update  out  1  one-cycle pulse in the cycle pattern_sel takes a new value.
frame_cnt  out  CNT_W  frames elapsed on the current pattern.
locked  out  1  set once the first frame boundary has been seen.

Behaviour:
- Reset (async, any time, including mid-frame or with a request pending):
  - pattern_sel=0, pattern_update=0, frame_cnt=0, locked=0, req_ready=0.
  - Pending request is dropped; vs_d=~VS_POL; state=WAIT_SYNC.
- Frame boundary detection:
  - vs_d is a registered copy of vs_in.
  - frame_start = (vs_in==VS_POL) && (vs_d!=VS_POL), combinational.
  - All updates caused by frame_start take effect at the next clk edge, so latency is 1 clk from the first cycle vs_in is sampled active.
  - A vs_in held active produces exactly one frame_start.
- FSM with 3 states:
  - WAIT_SYNC: req_ready=0, outputs held at reset values. On frame_start: locked<=1, frame_cnt<=0, go to RUN. No pattern_update pulse.
  - RUN: req_ready=1. If a request is accepted (req_valid && req_ready), latch the index into pend_pat and go to PEND.
  - PEND: req_ready=0. Further requests are back-pressured, and req_valid may stay high indefinitely.
- Request index clamping: if req_pattern >= NUM_PATTERNS, pend_pat = NUM_PATTERNS-1.
- Frame_start actions, evaluated with the state held before the edge:
  - PEND: pattern_sel<=pend_pat, frame_cnt<=0, pattern_update<=1, go to RUN. This applies even when pend_pat equals the current pattern_sel.
  - RUN, mode_auto=1, frame_cnt==FRAMES_PER_PATTERN-1:
    - pattern_sel<=pattern_sel+1, wrapping from NUM_PATTERNS-1 to 0.
    - frame_cnt<=0, pattern_update<=1.
  - RUN, otherwise: frame_cnt<=frame_cnt+1, saturating at 2^CNT_W-1; pattern_sel unchanged.
- Simultaneous request acceptance and frame_start in RUN:
  - The frame_start is handled as RUN, including any auto advance.
  - The accepted request is applied at the following frame_start.
- A manual request is always honoured in both modes. In auto mode, cycling resumes from the requested pattern with a full dwell.
- mode_auto rising edge (registered): frame_cnt<=0 at the next clk, giving a full dwell before the first auto advance.
  - If this coincides with a frame_start, the zeroing wins and no advance occurs.
- mode_auto=0: pattern held indefinitely; frame_cnt keeps counting and saturates.
- pattern_update is high for exactly 1 clk per change; it is 0 in all other cycles.

Test Plan:
- Auto cycling: NUM_PATTERNS=4, FRAMES_PER_PATTERN=3, mode_auto=1, 14 vs pulses -> the first pulse locks with no update; pattern_sel sequence 0,1,2,3,0 changes on pulses 4,7,10,13; each change is 1 clk after vs_in goes active and carries a single-cycle pattern_update.
- Manual request: mode_auto=0, locked, req_pattern=2 held valid for 5 clk -> req_ready falls 1 clk after acceptance; pattern_sel=2 one clk after the next frame_start; frame_cnt=0; req_ready=1 again.
- Collision: req_valid accepted in the same cycle as a frame_start that would auto-advance 1->2 -> pattern_sel=2 on this frame, then the requested value on the next frame_start.
- Clamp and polarity: VS_POL=0, NUM_PATTERNS=5, req_pattern=7 -> pattern_sel=4 one clk after vs_in falls; a vs_in held low for 3 lines gives only one update.
- Reset mid-operation: assert rst while in PEND with pattern_sel=3 -> all outputs go to 0 immediately with no clk; the pending request is discarded; after release the first frame_start sets locked=1 and pattern_sel stays 0.
- mode_auto toggle: auto at frame_cnt=2 (dwell 3), drop mode_auto for 10 frames, then raise it -> no change while low; frame_cnt restarts at 0; advance occurs exactly 3 frames after re-enable.

Source files
------------

// File: rtl/pattern_scheduler.sv
// Frame-synchronous test-pattern selector: auto-cycles patterns or applies manual requests,
// always switching on a vertical-sync boundary so no frame is torn.
module pattern_scheduler #(
    parameter int unsigned NUM_PATTERNS       = 8,
    parameter int unsigned SEL_W              = 3,
    parameter int unsigned FRAMES_PER_PATTERN = 60,
    parameter int unsigned CNT_W              = 8,
    parameter logic        VS_POL             = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vs_in,
    input  logic             mode_auto,
    input  logic             req_valid,
    input  logic [SEL_W-1:0] req_pattern,
    output logic             req_ready,
    output logic [SEL_W-1:0] pattern_sel,
    output logic             pattern_update,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             locked
);

    localparam logic [SEL_W-1:0] LAST_PAT   = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StWaitSync, StRun, StPend} state_t;

    state_t           state;
    logic             vs_d;
    logic             mode_d;
    logic [SEL_W-1:0] pend_pat;

    logic             frame_start;
    logic             mode_rise;
    logic             accept;
    logic [SEL_W-1:0] req_clamped;
    logic [SEL_W-1:0] sel_next;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        frame_start = (vs_in == VS_POL) && (vs_d != VS_POL);
        mode_rise   = mode_auto && !mode_d;
        accept      = req_valid && req_ready;
        req_clamped = (req_pattern > LAST_PAT) ? LAST_PAT : req_pattern;
        sel_next    = (pattern_sel == LAST_PAT) ? '0 : pattern_sel + 1'b1;
        cnt_inc     = (frame_cnt == CNT_MAX) ? CNT_MAX : frame_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StWaitSync;
            vs_d           <= ~VS_POL;
            mode_d         <= 1'b0;
            pend_pat       <= '0;
            req_ready      <= 1'b0;
            pattern_sel    <= '0;
            pattern_update <= 1'b0;
            frame_cnt      <= '0;
            locked         <= 1'b0;
        end else begin
            vs_d           <= vs_in;
            mode_d         <= mode_auto;
            pattern_update <= 1'b0;
            unique case (state)
                StWaitSync: begin
                    if (frame_start) begin
                        locked    <= 1'b1;
                        frame_cnt <= '0;
                        req_ready <= 1'b1;
                        state     <= StRun;
                    end
                end
                StRun: begin
                    // A fresh auto enable restarts the dwell and overrides any advance.
                    if (mode_rise) begin
                        frame_cnt <= '0;
                    end else if (frame_start) begin
                        if (mode_auto && frame_cnt == DWELL_LAST) begin
                            pattern_sel    <= sel_next;
                            frame_cnt      <= '0;
                            pattern_update <= 1'b1;
                        end else begin
                            frame_cnt <= cnt_inc;
                        end
                    end
                    if (accept) begin
                        pend_pat  <= req_clamped;
                        req_ready <= 1'b0;
                        state     <= StPend;
                    end
                end
                StPend: begin
                    if (frame_start) begin
                        pattern_sel    <= pend_pat;
                        frame_cnt      <= '0;
                        pattern_update <= 1'b1;
                        req_ready      <= 1'b1;
                        state          <= StRun;
                    end else if (mode_rise) begin
                        frame_cnt <= '0;
                    end
                end
                default: begin
                    req_ready <= 1'b0;
                    state     <= StWaitSync;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Randomized and directed bench for pattern_scheduler, checked against a frame-level
// reference model that applies the scheduling rules directly.
module tb_pattern_scheduler;

    localparam int   NP   = 5;
    localparam int   SW   = 3;
    localparam int   FPP  = 3;
    localparam int   CW   = 3;
    localparam int   CMAX = (1 << CW) - 1;
    localparam logic VP   = 1'b0;

    logic          clk;
    logic          rst;
    logic          vs_in;
    logic          mode_auto;
    logic          req_valid;
    logic [SW-1:0] req_pattern;
    logic          req_ready;
    logic [SW-1:0] pattern_sel;
    logic          pattern_update;
    logic [CW-1:0] frame_cnt;
    logic          locked;

    pattern_scheduler #(
        .NUM_PATTERNS      (NP),
        .SEL_W             (SW),
        .FRAMES_PER_PATTERN(FPP),
        .CNT_W             (CW),
        .VS_POL            (VP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vs_in         (vs_in),
        .mode_auto     (mode_auto),
        .req_valid     (req_valid),
        .req_pattern   (req_pattern),
        .req_ready     (req_ready),
        .pattern_sel   (pattern_sel),
        .pattern_update(pattern_update),
        .frame_cnt     (frame_cnt),
        .locked        (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic          m_locked;
    logic          m_pend;
    logic [SW-1:0] m_pend_pat;
    logic [SW-1:0] m_sel;
    int            m_cnt;
    logic          m_upd;
    logic          m_vs_prev;
    logic          m_mode_prev;
    logic          cur_mode;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked    = 1'b0;
        m_pend      = 1'b0;
        m_pend_pat  = '0;
        m_sel       = '0;
        m_cnt       = 0;
        m_upd       = 1'b0;
        m_vs_prev   = ~VP;
        m_mode_prev = 1'b0;
    endtask

    task automatic check_all();
        check("pattern_sel", 8'(pattern_sel), 8'(m_sel));
        check("pattern_update", 8'(pattern_update), 8'(m_upd));
        check("frame_cnt", 8'(frame_cnt), 8'(m_cnt));
        check("locked", 8'(locked), 8'(m_locked));
        check("req_ready", 8'(req_ready), 8'(m_locked && !m_pend));
    endtask

    // Drive one clock of inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic vs, input logic mode, input logic valid,
                         input logic [SW-1:0] pat);
        logic fs;
        logic rise;
        logic ready;
        vs_in       = vs;
        mode_auto   = mode;
        req_valid   = valid;
        req_pattern = pat;
        fs    = (vs == VP) && (m_vs_prev != VP);
        rise  = mode && !m_mode_prev;
        ready = m_locked && !m_pend;
        m_upd = 1'b0;
        if (!m_locked) begin
            if (fs) begin
                m_locked = 1'b1;
                m_cnt    = 0;
            end
        end else if (m_pend) begin
            if (fs) begin
                m_sel  = m_pend_pat;
                m_cnt  = 0;
                m_upd  = 1'b1;
                m_pend = 1'b0;
            end else if (rise) begin
                m_cnt = 0;
            end
        end else begin
            if (rise) begin
                m_cnt = 0;
            end else if (fs) begin
                if (mode && m_cnt == FPP - 1) begin
                    m_sel = SW'((int'(m_sel) + 1) % NP);
                    m_cnt = 0;
                    m_upd = 1'b1;
                end else begin
                    m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
                end
            end
            if (valid && ready) begin
                m_pend     = 1'b1;
                m_pend_pat = (int'(pat) >= NP) ? SW'(NP - 1) : pat;
            end
        end
        m_vs_prev   = vs;
        m_mode_prev = mode;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run_frames(input int n, input bit toggle, input int req_pct);
        for (int f = 0; f < n; f++) begin
            int act;
            int gap;
            act = int'($urandom_range(1, 3));
            gap = int'($urandom_range(4, 9));
            for (int i = 0; i < act + gap; i++) begin
                logic          v;
                logic [SW-1:0] p;
                if (toggle && $urandom_range(0, 39) == 0) cur_mode = ~cur_mode;
                v = ($urandom_range(0, 99) < 32'(req_pct));
                p = SW'($urandom_range(0, 7));
                cycle((i < act) ? VP : ~VP, cur_mode, v, p);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        vs_in       = ~VP;
        mode_auto   = 1'b0;
        req_valid   = 1'b0;
        req_pattern = '0;
        cur_mode    = 1'b0;
        model_reset();
        #12;
        check("reset_sel", 8'(pattern_sel), 8'd0);
        check("reset_update", 8'(pattern_update), 8'd0);
        check("reset_cnt", 8'(frame_cnt), 8'd0);
        check("reset_locked", 8'(locked), 8'd0);
        check("reset_ready", 8'(req_ready), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Auto cycling: 14 frames, first one only locks.
        cur_mode = 1'b1;
        run_frames(14, 1'b0, 0);
        check("auto_final_sel", 8'(pattern_sel), 8'd4);
        check("auto_locked", 8'(locked), 8'd1);

        // Manual request held valid for 5 clocks while holding.
        cur_mode = 1'b0;
        run_frames(2, 1'b0, 0);
        for (int i = 0; i < 5; i++) cycle(~VP, 1'b0, 1'b1, 3'd2);
        check("manual_backpressure", 8'(req_ready), 8'd0);
        run_frames(1, 1'b0, 0);
        check("manual_sel", 8'(pattern_sel), 8'd2);
        check("manual_cnt", 8'(frame_cnt), 8'd0);

        // Clamped request, then a long active sync gives only one update.
        for (int i = 0; i < 2; i++) cycle(~VP, 1'b0, 1'b1, 3'd7);
        for (int i = 0; i < 20; i++) cycle(VP, 1'b0, 1'b0, 3'd0);
        check("clamp_sel", 8'(pattern_sel), 8'd4);
        for (int i = 0; i < 4; i++) cycle(~VP, 1'b0, 1'b0, 3'd0);

        // Mixed random traffic with mode toggling and out-of-range requests.
        run_frames(40, 1'b1, 10);

        // Reset while a request is pending on top of pattern 3.
        cur_mode = 1'b0;
        run_frames(1, 1'b0, 0);
        for (int i = 0; i < 2; i++) cycle(~VP, 1'b0, 1'b1, 3'd3);
        run_frames(1, 1'b0, 0);
        check("pre_reset_sel", 8'(pattern_sel), 8'd3);
        for (int i = 0; i < 2; i++) cycle(~VP, 1'b0, 1'b1, 3'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_sel", 8'(pattern_sel), 8'd0);
        check("async_rst_locked", 8'(locked), 8'd0);
        check("async_rst_ready", 8'(req_ready), 8'd0);
        check("async_rst_cnt", 8'(frame_cnt), 8'd0);
        vs_in     = ~VP;
        req_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(~VP, 1'b0, 1'b0, 3'd0);
        run_frames(1, 1'b0, 0);
        check("post_rst_locked", 8'(locked), 8'd1);
        check("post_rst_sel", 8'(pattern_sel), 8'd0);

        // Re-enable auto and keep mixing.
        cur_mode = 1'b1;
        run_frames(25, 1'b1, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
